// File: rtl/i2c_defines_pkg.sv
// Shared I2C definitions: controller and target state encodings plus common widths.
package i2c_defines;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    CTRL_IDLE,
    CTRL_START,
    CTRL_ADDR,
    CTRL_DATA,
    CTRL_ACK,
    CTRL_STOP
  } i2c_ctrl_state_t;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_target_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line with rise/fall detection on the synced level.
module i2c_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic async_input,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Idle bus lines are high, so all stages reset to 1 to avoid a false edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= async_input;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit auto-incrementing register pointer and a simple register strobe interface.
module i2c_target
  import i2c_defines::*;
#(
  parameter logic [6:0] ADDRESS = 7'h50
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scl_input,
  output logic              scl_output,
  input  logic              sda_input,
  output logic              sda_output,
  output logic [DATA_W-1:0] reg_address,
  output logic              reg_write,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              reg_read,
  input  logic [DATA_W-1:0] reg_read_data,
  output logic              busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clock       (clock),
    .reset       (reset),
    .async_input (scl_input),
    .level       (scl_level),
    .rise_c      (scl_rise),
    .fall_c      (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clock       (clock),
    .reset       (reset),
    .async_input (sda_input),
    .level       (sda_level),
    .rise_c      (sda_rise),
    .fall_c      (sda_fall)
  );

  logic start_c, stop_c;
  assign start_c = sda_fall & scl_level;
  assign stop_c  = sda_rise & scl_level;

  assign scl_output = 1'b1;

  i2c_target_state_t state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [DATA_W-1:0] addr_n, wdata_n;
  logic [DATA_W-1:0] rx_byte_c;
  logic              sda_n, write_n, read_n, busy_n;
  logic              load, load_n;

  assign rx_byte_c = {shift[DATA_W-2:0], sda_level};

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift          <= '0;
      sda_output     <= 1'b1;
      reg_address    <= '0;
      reg_write      <= 1'b0;
      reg_write_data <= '0;
      reg_read       <= 1'b0;
      busy           <= 1'b0;
      load           <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      shift          <= shift_n;
      sda_output     <= sda_n;
      reg_address    <= addr_n;
      reg_write      <= write_n;
      reg_write_data <= wdata_n;
      reg_read       <= read_n;
      busy           <= busy_n;
      load           <= load_n;
    end
  end

  // Next-state and datapath; START/STOP preempt any in-flight byte.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    sda_n     = sda_output;
    addr_n    = reg_address;
    wdata_n   = reg_write_data;
    write_n   = 1'b0;
    read_n    = 1'b0;
    busy_n    = busy;
    load_n    = reg_read;

    if (start_c) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_n     = 1'b1;
      busy_n    = 1'b0;
    end else if (stop_c) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_n     = 1'b1;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            shift_n   = rx_byte_c;
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
            if (bit_cnt == CNT_W'(7)) begin
              case (state)
                ADDR: begin
                  if (rx_byte_c[7:1] == ADDRESS) begin
                    state_n = ADDR_ACK;
                    busy_n  = 1'b1;
                  end else begin
                    state_n = IGNORE;
                  end
                end
                REG: begin
                  state_n = REG_ACK;
                  addr_n  = rx_byte_c;
                end
                default: begin
                  state_n = WDATA_ACK;
                  write_n = 1'b1;
                  wdata_n = rx_byte_c;
                end
              endcase
            end
          end
        end

        // Count 8: pull SDA low at the 8th fall; count 9: release at the 9th fall.
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == CNT_W'(8)) begin
              sda_n     = 1'b0;
              bit_cnt_n = CNT_W'(9);
            end else begin
              sda_n     = 1'b1;
              bit_cnt_n = '0;
              case (state)
                ADDR_ACK: begin
                  if (shift[0]) begin
                    state_n = RDATA;
                    read_n  = 1'b1;
                  end else begin
                    state_n = REG;
                  end
                end
                REG_ACK: state_n = WDATA;
                default: begin
                  state_n = WDATA;
                  addr_n  = DATA_W'(reg_address + DATA_W'(1));
                end
              endcase
            end
          end
        end

        RDATA: begin
          if (load) begin
            shift_n = reg_read_data;
            sda_n   = reg_read_data[DATA_W-1];
          end else if (scl_rise) begin
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
          end else if (scl_fall) begin
            if (bit_cnt == CNT_W'(8)) begin
              sda_n     = 1'b1;
              state_n   = RDATA_ACK;
              bit_cnt_n = '0;
            end else begin
              shift_n = {shift[DATA_W-2:0], 1'b0};
              sda_n   = shift[DATA_W-2];
            end
          end
        end

        // Next byte is fetched during the ACK clock but only driven after SCL falls.
        RDATA_ACK: begin
          if (load) begin
            shift_n = reg_read_data;
          end else if (scl_rise) begin
            if (!sda_level) begin
              addr_n    = DATA_W'(reg_address + DATA_W'(1));
              read_n    = 1'b1;
              bit_cnt_n = CNT_W'(1);
            end else begin
              state_n = IGNORE;
              sda_n   = 1'b1;
            end
          end else if (scl_fall && bit_cnt == CNT_W'(1)) begin
            state_n   = RDATA;
            sda_n     = shift[DATA_W-1];
            bit_cnt_n = '0;
          end
        end

        default: begin
          sda_n = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-level controller driving SCL/SDA and a small register model.
module tb_i2c_target;
  import i2c_defines::*;

  localparam int unsigned Q = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_ctrl = 1'b1;
  logic       sda_ctrl = 1'b1;
  logic       scl_output, sda_output;
  logic       sda_bus;
  logic [7:0] reg_address, reg_write_data;
  logic       reg_write, reg_read, busy;
  logic [7:0] reg_read_data = 8'h00;

  logic [7:0] mem [256];
  logic [7:0] w_addr_q [$];
  logic [7:0] w_data_q [$];
  logic [7:0] r_addr_q [$];
  int         sda_low_cycles = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  assign sda_bus = sda_ctrl & sda_output;

  i2c_target #(.ADDRESS(7'h50)) dut (
    .clock          (clock),
    .reset          (reset),
    .scl_input      (scl_ctrl),
    .scl_output     (scl_output),
    .sda_input      (sda_bus),
    .sda_output     (sda_output),
    .reg_address    (reg_address),
    .reg_write      (reg_write),
    .reg_write_data (reg_write_data),
    .reg_read       (reg_read),
    .reg_read_data  (reg_read_data),
    .busy           (busy)
  );

  // Register model: logs strobes and answers reads one cycle after the strobe.
  always @(posedge clock) begin
    if (reg_write) begin
      w_addr_q.push_back(reg_address);
      w_data_q.push_back(reg_write_data);
    end
    if (reg_read) begin
      r_addr_q.push_back(reg_address);
      reg_read_data <= mem[reg_address];
    end
    if (!sda_output) sda_low_cycles++;
  end

  task automatic wait_q();
    repeat (Q) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_ctrl = b;
    wait_q();
    scl_ctrl = 1'b1;
    wait_q();
    s = sda_bus;
    scl_ctrl = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(ack, s);
  endtask

  task automatic bus_start();
    sda_ctrl = 1'b1;
    scl_ctrl = 1'b1;
    wait_q();
    sda_ctrl = 1'b0;
    wait_q();
    scl_ctrl = 1'b0;
    wait_q();
  endtask

  task automatic bus_rstart();
    sda_ctrl = 1'b1;
    wait_q();
    scl_ctrl = 1'b1;
    wait_q();
    sda_ctrl = 1'b0;
    wait_q();
    scl_ctrl = 1'b0;
    wait_q();
  endtask

  task automatic bus_stop();
    sda_ctrl = 1'b0;
    wait_q();
    scl_ctrl = 1'b1;
    wait_q();
    sda_ctrl = 1'b1;
    wait_q();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (sda_output !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", sda_output); end
    checks++; if (scl_output !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b expected 1", scl_output); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b expected 0", reg_write); end
    checks++; if (reg_read !== 1'b0) begin errors++; $display("FAIL reset_reg_read: got %b expected 0", reg_read); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (reg_address !== 8'h00) begin errors++; $display("FAIL reset_reg_address: got %h expected 00", reg_address); end
    checks++; if (reg_write_data !== 8'h00) begin errors++; $display("FAIL reset_reg_write_data: got %h expected 00", reg_write_data); end
    reset = 1'b0;
    wait_q();
  endtask

  task automatic test_write();
    logic [3:0] acks;
    int wb;
    logic [7:0] a0, d0, a1, d1;
    wb = w_addr_q.size();
    bus_start();
    write_byte(8'hA0, acks[3]);
    write_byte(8'h10, acks[2]);
    write_byte(8'hA5, acks[1]);
    write_byte(8'h3C, acks[0]);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_active: got %b expected 1", busy); end
    bus_stop();
    checks++; if (acks !== 4'b0000) begin errors++; $display("FAIL write_acks: got %b expected 0000", acks); end
    checks++; if (w_addr_q.size() - wb !== 2) begin errors++; $display("FAIL write_count: got %0d expected 2", w_addr_q.size() - wb); end
    a0 = (w_addr_q.size() > wb) ? w_addr_q[wb] : 8'hxx;
    d0 = (w_addr_q.size() > wb) ? w_data_q[wb] : 8'hxx;
    a1 = (w_addr_q.size() > wb + 1) ? w_addr_q[wb+1] : 8'hxx;
    d1 = (w_addr_q.size() > wb + 1) ? w_data_q[wb+1] : 8'hxx;
    checks++; if ({a0, d0} !== 16'h10A5) begin errors++; $display("FAIL write_first: got %h/%h expected 10/a5", a0, d0); end
    checks++; if ({a1, d1} !== 16'h113C) begin errors++; $display("FAIL write_second: got %h/%h expected 11/3c", a1, d1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    checks++; if (reg_address !== 8'h12) begin errors++; $display("FAIL write_pointer: got %h expected 12", reg_address); end
  endtask

  task automatic test_ignore();
    logic ack0, ack1;
    int wb, rb, lb;
    wb = w_addr_q.size();
    rb = r_addr_q.size();
    lb = sda_low_cycles;
    bus_start();
    write_byte(8'hA2, ack0);
    write_byte(8'h10, ack1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %b expected 0", busy); end
    bus_stop();
    checks++; if ({ack0, ack1} !== 2'b11) begin errors++; $display("FAIL ignore_acks: got %b expected 11", {ack0, ack1}); end
    checks++; if (sda_low_cycles - lb !== 0) begin errors++; $display("FAIL ignore_sda_low: got %0d cycles expected 0", sda_low_cycles - lb); end
    checks++; if (w_addr_q.size() - wb !== 0) begin errors++; $display("FAIL ignore_writes: got %0d expected 0", w_addr_q.size() - wb); end
    checks++; if (r_addr_q.size() - rb !== 0) begin errors++; $display("FAIL ignore_reads: got %0d expected 0", r_addr_q.size() - rb); end
  endtask

  task automatic test_read();
    logic ack0, ack1, ack2;
    logic [7:0] d0, d1, ra0, ra1;
    int wb, rb;
    mem[8'h20] = 8'h11;
    mem[8'h21] = 8'h22;
    wb = w_addr_q.size();
    rb = r_addr_q.size();
    bus_start();
    write_byte(8'hA0, ack0);
    write_byte(8'h20, ack1);
    bus_rstart();
    write_byte(8'hA1, ack2);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    checks++; if (sda_output !== 1'b1) begin errors++; $display("FAIL read_release_after_nack: got %b expected 1", sda_output); end
    checks++; if (dut.state !== IGNORE) begin errors++; $display("FAIL read_state_after_nack: got %0d expected %0d", dut.state, IGNORE); end
    bus_stop();
    checks++; if ({ack0, ack1, ack2} !== 3'b000) begin errors++; $display("FAIL read_acks: got %b expected 000", {ack0, ack1, ack2}); end
    checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL read_byte0: got %h expected 11", d0); end
    checks++; if (d1 !== 8'h22) begin errors++; $display("FAIL read_byte1: got %h expected 22", d1); end
    checks++; if (r_addr_q.size() - rb !== 2) begin errors++; $display("FAIL read_count: got %0d expected 2", r_addr_q.size() - rb); end
    ra0 = (r_addr_q.size() > rb) ? r_addr_q[rb] : 8'hxx;
    ra1 = (r_addr_q.size() > rb + 1) ? r_addr_q[rb+1] : 8'hxx;
    checks++; if ({ra0, ra1} !== 16'h2021) begin errors++; $display("FAIL read_addrs: got %h,%h expected 20,21", ra0, ra1); end
    checks++; if (w_addr_q.size() - wb !== 0) begin errors++; $display("FAIL read_no_writes: got %0d expected 0", w_addr_q.size() - wb); end
  endtask

  task automatic test_wrap();
    logic [2:0] acks;
    logic [3:0] unused_ack;
    int wb;
    logic [7:0] a0, d0, a1, d1;
    wb = w_addr_q.size();
    bus_start();
    write_byte(8'hA0, unused_ack[0]);
    write_byte(8'hFF, acks[2]);
    write_byte(8'h01, acks[1]);
    write_byte(8'h02, acks[0]);
    bus_stop();
    a0 = (w_addr_q.size() > wb) ? w_addr_q[wb] : 8'hxx;
    d0 = (w_addr_q.size() > wb) ? w_data_q[wb] : 8'hxx;
    a1 = (w_addr_q.size() > wb + 1) ? w_addr_q[wb+1] : 8'hxx;
    d1 = (w_addr_q.size() > wb + 1) ? w_data_q[wb+1] : 8'hxx;
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL wrap_acks: got %b expected 000", acks); end
    checks++; if ({a0, d0} !== 16'hFF01) begin errors++; $display("FAIL wrap_first: got %h/%h expected ff/01", a0, d0); end
    checks++; if ({a1, d1} !== 16'h0002) begin errors++; $display("FAIL wrap_second: got %h/%h expected 00/02", a1, d1); end
    checks++; if (reg_address !== 8'h01) begin errors++; $display("FAIL wrap_pointer: got %h expected 01", reg_address); end
  endtask

  task automatic test_stop_mid_byte();
    logic ack, s;
    int wb;
    logic [7:0] a0, d0;
    logic [3:0] bits;
    bits = 4'b1010;
    wb = w_addr_q.size();
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h30, ack);
    for (int i = 3; i >= 0; i--) send_bit(bits[i], s);
    bus_stop();
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL stop_mid_state: got %0d expected %0d", dut.state, IDLE); end
    checks++; if (w_addr_q.size() - wb !== 0) begin errors++; $display("FAIL stop_mid_no_write: got %0d expected 0", w_addr_q.size() - wb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_mid_busy: got %b expected 0", busy); end
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    write_byte(8'h77, ack);
    bus_stop();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL stop_mid_recover_ack: got %b expected 0", ack); end
    a0 = (w_addr_q.size() > wb) ? w_addr_q[wb] : 8'hxx;
    d0 = (w_addr_q.size() > wb) ? w_data_q[wb] : 8'hxx;
    checks++; if ({a0, d0} !== 16'h4077) begin errors++; $display("FAIL stop_mid_recover_write: got %h/%h expected 40/77", a0, d0); end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    mem[8'h41] = 8'h0F;
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (sda_output !== 1'b0) begin errors++; $display("FAIL reset_mid_driving: got %b expected 0", sda_output); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (sda_output !== 1'b1) begin errors++; $display("FAIL reset_mid_sda: got %b expected 1", sda_output); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_mid_state: got %0d expected %0d", dut.state, IDLE); end
    checks++; if (reg_read !== 1'b0 || reg_write !== 1'b0) begin errors++; $display("FAIL reset_mid_strobes: got %b%b expected 00", reg_read, reg_write); end
    @(negedge clock);
    reset = 1'b0;
    bus_stop();
    checks++; if (reg_address !== 8'h00) begin errors++; $display("FAIL reset_mid_pointer: got %h expected 00", reg_address); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_ignore();
    test_read();
    test_wrap();
    test_stop_mid_byte();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
